// File: rtl/conv_mem_pkg.sv
// Shared definitions for the convolutor memory arbiter: requester indices,
// the round-robin pointer type and small index helpers.
package conv_mem_pkg;

    localparam int NUM_REQ     = 3;
    localparam int REQ_HOST    = 0;
    localparam int REQ_CORE_RD = 1;
    localparam int REQ_CORE_WR = 2;

    typedef logic [1:0] ptr_t;

    // Pointer moves to the requester just after the winner, wrapping at 3.
    function automatic ptr_t next_ptr(input logic [NUM_REQ-1:0] win);
        ptr_t p;
        p = 2'd0;
        if (win[REQ_HOST])    p = 2'd1;
        if (win[REQ_CORE_RD]) p = 2'd2;
        if (win[REQ_CORE_WR]) p = 2'd0;
        return p;
    endfunction

    function automatic ptr_t onehot_to_idx(input logic [NUM_REQ-1:0] oh);
        ptr_t p;
        p = 2'd0;
        if (oh[REQ_CORE_RD]) p = 2'd1;
        if (oh[REQ_CORE_WR]) p = 2'd2;
        return p;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: first set request bit starting at ptr_i,
// searching ptr_i, ptr_i+1, ptr_i+2 (mod 3).
module rr_priority_pick
    import conv_mem_pkg::*;
(
    input  logic [2:0] req_i,
    input  ptr_t       ptr_i,
    output logic [2:0] win_o,
    output logic       valid_o
);

    always_comb begin
        int idx;
        idx     = 0;
        win_o   = '0;
        valid_o = |req_i;
        // Walk from the lowest priority upward so the nearest-to-ptr request wins last.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = (int'(ptr_i) + i) % NUM_REQ;
            if (req_i[idx]) begin
                win_o      = '0;
                win_o[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/conv_mem_arbiter.sv
// Three-way round-robin arbiter sharing one single-port RAM between the host
// and the convolutor core; host writes are refused while the core is busy.
module conv_mem_arbiter
    import conv_mem_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    core_busy_i,
    input  logic [2:0]              req_i,
    input  logic [2:0]              we_i,
    input  logic [3*ADDR_W-1:0]     addr_i,
    input  logic [3*DATA_W-1:0]     wdata_i,
    output logic [2:0]              gnt_o,
    output logic [2:0]              rvalid_o,
    output logic [DATA_W-1:0]       rdata_o,
    output logic                    host_err_o,
    output logic                    mem_en_o,
    output logic                    mem_we_o,
    output logic [ADDR_W-1:0]       mem_addr_o,
    output logic [DATA_W-1:0]       mem_wdata_o,
    input  logic [DATA_W-1:0]       mem_rdata_i
);

    ptr_t              ptr_q, ptr_d;
    logic [2:0]        gnt_q, gnt_d;
    logic              host_err_q, host_err_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    ptr_t              rd_idx_q, rd_idx_d;
    logic              rd_flag_q, rd_flag_d;

    logic [2:0]        masked_req;
    logic [2:0]        win;
    logic              win_valid;

    // A requester holding its grant this cycle sits out, so one handshake = one access.
    assign masked_req = req_i & ~gnt_q;

    rr_priority_pick u_pick (
        .req_i   (masked_req),
        .ptr_i   (ptr_q),
        .win_o   (win),
        .valid_o (win_valid)
    );

    always_comb begin
        ptr_d       = ptr_q;
        gnt_d       = '0;
        host_err_d  = 1'b0;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        rd_flag_d   = mem_en_q & ~mem_we_q;
        rd_idx_d    = onehot_to_idx(gnt_q);

        if (win_valid) begin
            ptr_d    = next_ptr(win);
            gnt_d    = win;
            mem_en_d = 1'b1;
            for (int k = 0; k < NUM_REQ; k++) begin
                if (win[k]) begin
                    mem_we_d    = we_i[k];
                    mem_addr_d  = addr_i[k*ADDR_W +: ADDR_W];
                    mem_wdata_d = wdata_i[k*DATA_W +: DATA_W];
                end
            end
            // Host write during core computation keeps its slot but never touches RAM.
            if (win[REQ_HOST] && we_i[REQ_HOST] && core_busy_i) begin
                host_err_d = 1'b1;
                mem_en_d   = 1'b0;
                mem_we_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= 2'd0;
            gnt_q       <= '0;
            host_err_q  <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rd_idx_q    <= 2'd0;
            rd_flag_q   <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            host_err_q  <= host_err_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rd_idx_q    <= rd_idx_d;
            rd_flag_q   <= rd_flag_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign host_err_o  = host_err_q;
    assign mem_en_o    = mem_en_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign rvalid_o    = rd_flag_q ? (3'b001 << rd_idx_q) : 3'b000;
    assign rdata_o     = rd_flag_q ? mem_rdata_i : '0;

endmodule

// File: tb/tb_conv_mem_arbiter.sv
// Directed bench for conv_mem_arbiter with a small registered-read RAM model.
module tb_conv_mem_arbiter;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                core_busy;
    logic [2:0]          req, we;
    logic [3*ADDR_W-1:0] addr;
    logic [3*DATA_W-1:0] wdata;
    logic [2:0]          gnt, rvalid;
    logic [DATA_W-1:0]   rdata;
    logic                host_err, mem_en, mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   mem_rdata;

    logic [DATA_W-1:0]   ram [0:(1<<ADDR_W)-1];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    conv_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .core_busy_i (core_busy),
        .req_i       (req),
        .we_i        (we),
        .addr_i      (addr),
        .wdata_i     (wdata),
        .gnt_o       (gnt),
        .rvalid_o    (rvalid),
        .rdata_o     (rdata),
        .host_err_o  (host_err),
        .mem_en_o    (mem_en),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata)
    );

    // RAM model: word i preloads to A000_0000+i while reset is held, except word 7.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < (1 << ADDR_W); i++) ram[i] <= 32'hA000_0000 + i;
            ram[7] <= 32'hDEAD_BEEF;
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req = '0; we = '0; addr = '0; wdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        core_busy = 1'b0;
        idle_inputs();
        mem_rdata = '0;
        do_reset();

        check("rst_gnt", {29'd0, gnt}, 32'd0);
        check("rst_rvalid", {29'd0, rvalid}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_mem_en", {31'd0, mem_en}, 32'd0);
        check("rst_host_err", {31'd0, host_err}, 32'd0);

        // Single core read of word 7.
        req = 3'b010; addr[1*ADDR_W +: ADDR_W] = 5'd7;
        tick();
        check("rd7_gnt", {29'd0, gnt}, 32'h2);
        check("rd7_mem_en", {31'd0, mem_en}, 32'd1);
        check("rd7_mem_we", {31'd0, mem_we}, 32'd0);
        check("rd7_addr", {27'd0, mem_addr}, 32'd7);
        check("rd7_rvalid_early", {29'd0, rvalid}, 32'd0);
        idle_inputs();
        tick();
        check("rd7_gnt_off", {29'd0, gnt}, 32'd0);
        check("rd7_rvalid", {29'd0, rvalid}, 32'h2);
        check("rd7_rdata", rdata, 32'hDEAD_BEEF);
        tick();
        check("rd7_rvalid_off", {29'd0, rvalid}, 32'd0);
        check("rd7_rdata_zero", rdata, 32'd0);
        check("idle_mem_en", {31'd0, mem_en}, 32'd0);

        // All three read at once from ptr=0.
        do_reset();
        req = 3'b111; we = 3'b000;
        addr = {5'd4, 5'd2, 5'd1};
        tick();
        check("all_g0", {29'd0, gnt}, 32'h1);
        check("all_a0", {27'd0, mem_addr}, 32'd1);
        tick();
        check("all_g1", {29'd0, gnt}, 32'h2);
        check("all_a1", {27'd0, mem_addr}, 32'd2);
        check("all_rv0", {29'd0, rvalid}, 32'h1);
        check("all_rd0", rdata, 32'hA000_0001);
        tick();
        check("all_g2", {29'd0, gnt}, 32'h4);
        check("all_a2", {27'd0, mem_addr}, 32'd4);
        check("all_rv1", {29'd0, rvalid}, 32'h2);
        check("all_rd1", rdata, 32'hA000_0002);
        idle_inputs();
        tick();
        check("all_g_off", {29'd0, gnt}, 32'd0);
        check("all_rv2", {29'd0, rvalid}, 32'h4);
        check("all_rd2", rdata, 32'hA000_0004);
        req = 3'b111;
        tick();
        check("all_ptr_back0", {29'd0, gnt}, 32'h1);
        idle_inputs();
        tick();
        tick();

        // Host write refused while the core is busy.
        do_reset();
        core_busy = 1'b1;
        req = 3'b001; we = 3'b001; addr[0 +: ADDR_W] = 5'd3; wdata[0 +: DATA_W] = 32'h1234;
        tick();
        check("busy_gnt", {29'd0, gnt}, 32'h1);
        check("busy_err", {31'd0, host_err}, 32'd1);
        check("busy_mem_en", {31'd0, mem_en}, 32'd0);
        idle_inputs();
        tick();
        check("busy_err_off", {31'd0, host_err}, 32'd0);
        req = 3'b001; addr[0 +: ADDR_W] = 5'd3;
        tick();
        check("busy_rd_gnt", {29'd0, gnt}, 32'h1);
        check("busy_rd_en", {31'd0, mem_en}, 32'd1);
        idle_inputs();
        tick();
        check("busy_rd_rv", {29'd0, rvalid}, 32'h1);
        check("busy_rd_old", rdata, 32'hA000_0003);
        core_busy = 1'b0;

        // Same host write with the core idle.
        req = 3'b001; we = 3'b001; addr[0 +: ADDR_W] = 5'd3; wdata[0 +: DATA_W] = 32'h1234;
        tick();
        check("wr_gnt", {29'd0, gnt}, 32'h1);
        check("wr_we", {31'd0, mem_we}, 32'd1);
        check("wr_addr", {27'd0, mem_addr}, 32'd3);
        check("wr_data", mem_wdata, 32'h1234);
        check("wr_err", {31'd0, host_err}, 32'd0);
        idle_inputs();
        tick();
        req = 3'b001; addr[0 +: ADDR_W] = 5'd3;
        tick();
        idle_inputs();
        tick();
        check("wr_rd_rv", {29'd0, rvalid}, 32'h1);
        check("wr_rd_new", rdata, 32'h1234);

        // Host and core write both requesting continuously.
        do_reset();
        req = 3'b101; we = 3'b101;
        addr = {5'd11, 5'd0, 5'd10};
        wdata = {32'hC0DE_0002, 32'd0, 32'hC0DE_0000};
        tick();
        check("alt_g0", {29'd0, gnt}, 32'h1);
        check("alt_a0", {27'd0, mem_addr}, 32'd10);
        tick();
        check("alt_g1", {29'd0, gnt}, 32'h4);
        check("alt_a1", {27'd0, mem_addr}, 32'd11);
        tick();
        check("alt_g2", {29'd0, gnt}, 32'h1);
        tick();
        check("alt_g3", {29'd0, gnt}, 32'h4);
        check("alt_d3", mem_wdata, 32'hC0DE_0002);
        idle_inputs();
        tick();

        // Reset right after a read grant.
        do_reset();
        req = 3'b010; addr[1*ADDR_W +: ADDR_W] = 5'd7;
        tick();
        check("rr_gnt", {29'd0, gnt}, 32'h2);
        idle_inputs();
        #2;
        rst_n = 1'b0;
        #1;
        check("rr_gnt_clr", {29'd0, gnt}, 32'd0);
        check("rr_en_clr", {31'd0, mem_en}, 32'd0);
        check("rr_rv_clr", {29'd0, rvalid}, 32'd0);
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("rr_no_rv%0d", c), {29'd0, rvalid}, 32'd0);
            check($sformatf("rr_rdata%0d", c), rdata, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Grants and read-valids never carry more than one bit.
    always @(negedge clk) begin
        if (rst_n) begin
            if (!$onehot0(gnt) || !$onehot0(rvalid)) begin
                total++;
                bad++;
                $display("FAIL onehot: gnt %b rvalid %b required one-hot or zero", gnt, rvalid);
            end
        end
    end

endmodule
